mc_control_fsm: RTL
===================

Name: mc_control_fsm

Overview:
Multi-cycle sequencer for the 32-bit MIPS datapath. It replaces per-instruction combinational decode with a Moore state machine that steps shared resources (single memory port, single ALU, IR/PC registers) through fetch, decode, execute, memory and write-back phases. It supports R-type, lw, sw, beq, bne, j, lui and slti. Memory accesses use a ready handshake with a timeout watchdog. The block sits between the instruction register opcode field and the datapath mux/enable controls.

Parameters:
MEM_TIMEOUT, 255, maximum wait cycles for mem_ready per access before fault (1..65535)
TO_W, 16, width of the wait counter; must hold MEM_TIMEOUT

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
run  in  1  start/continue execution; sampled only in IDLE
opcode  in  6  IR[31:26]; valid and stable from DECODE until next FETCH
mem_ready  in  1  memory completes current read/write this cycle
pc_write  out  1  unconditional PC load
pc_write_cond  out  1  PC load if ALU zero (beq)
pc_write_cond_ne  out  1  PC load if ALU not zero (bne)
i_or_d  out  1  memory address: 0=PC, 1=ALUOut
mem_read  out  1  memory read request
mem_write  out  1  memory write request
ir_write  out  1  IR load
reg_dst  out  1  write-register select: 1=rd, 0=rt
mem_to_reg  out  1  write-back data select: 1=MDR, 0=ALUOut
reg_write  out  1  register file write enable
alu_src_a  out  1  0=PC, 1=rs
alu_src_b  out  2  00=rt, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2
alu_op  out  2  00=add, 01=sub, 10=funct field, 11=set-less-than
pc_source  out  2  00=ALU result, 01=ALUOut, 10=jump target
lu_write  out  1  write imm<<16 to rt (lui)
slti_en  out  1  slti compare path enable
fault  out  1  sticky fault flag
illegal_op  out  1  sticky: fault caused by unknown opcode
state_out  out  4  current state encoding, for debug

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; wait counter=0; fault=0; illegal_op=0. All control outputs are 0 in IDLE. Reset mid-instruction abandons it immediately with no partial write.
- Control outputs are Moore decodes of the state. The exceptions are ir_write and pc_write in FETCH, which equal mem_ready.
- IDLE(0): if run=1, go to FETCH; otherwise stay.
- FETCH(1): mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00. Hold until mem_ready=1. On that cycle, ir_write=pc_write=1 and go to DECODE.
- DECODE(2): alu_src_a=0, alu_src_b=11, alu_op=00 (branch target into ALUOut). Next state by opcode:
  - 000000 -> EXEC_R
  - 100011 or 101011 -> MEM_ADDR
  - 000100 or 000101 -> BRANCH
  - 000010 -> JUMP
  - 001111 -> LUI_WB
  - 001010 -> SLTI_EX
  - any other opcode -> FAULT with illegal_op=1
- EXEC_R(3): alu_src_a=1, alu_src_b=00, alu_op=10. Next: R_WB.
- R_WB(4): reg_dst=1, reg_write=1, mem_to_reg=0. Next: FETCH.
- MEM_ADDR(5): alu_src_a=1, alu_src_b=10, alu_op=00. Next: MEM_RD for lw, MEM_WR for sw.
- MEM_RD(6): mem_read=1, i_or_d=1. Hold until mem_ready, then go to MEM_WB.
- MEM_WB(7): reg_dst=0, mem_to_reg=1, reg_write=1. Next: FETCH.
- MEM_WR(8): mem_write=1, i_or_d=1. Hold until mem_ready, then go to FETCH.
- BRANCH(9): alu_src_a=1, alu_src_b=00, alu_op=01, pc_source=01. pc_write_cond=1 for beq; pc_write_cond_ne=1 for bne. Next: FETCH.
- JUMP(10): pc_write=1, pc_source=10. Next: FETCH.
- LUI_WB(11): lu_write=1, reg_write=1, reg_dst=0. Next: FETCH.
- SLTI_EX(12): alu_src_a=1, alu_src_b=10, alu_op=11, slti_en=1. Next: SLTI_WB.
- SLTI_WB(13): slti_en=1, reg_write=1, reg_dst=0, mem_to_reg=0. Next: FETCH.
- FAULT(14): all controls 0, fault=1. Exit only by reset.
- Cycles per instruction with zero-wait memory: R=4, lw=5, sw=4, beq/bne=3, j=3, lui=3, slti=4.
- Each memory wait adds one cycle.
- Wait counter: cleared on entry to FETCH, MEM_RD or MEM_WR, and on mem_ready. It increments each cycle in those states while mem_ready=0. If it reaches MEM_TIMEOUT with mem_ready still 0, go to FAULT (illegal_op=0). mem_ready on the same cycle as the timeout wins, and the access completes.
- mem_ready is ignored outside FETCH, MEM_RD and MEM_WR.
- run is ignored outside IDLE.

Optional Feature:
PERF_CNT_EN: when defined, adds 32-bit outputs cycle_cnt and instr_cnt, both reset to 0.
- cycle_cnt increments every cycle while state is not IDLE or FAULT.
- instr_cnt increments on each transition into FETCH from a non-IDLE state (instruction retire).
- Both wrap at 2^32.
When not defined, these ports and counters do not exist, and the FSM behaviour is identical.

Test Plan:
- Reset, then run=1, opcode=000000, mem_ready=1 -> states 0,1,2,3,4,1. R_WB has reg_write=1 and reg_dst=1. 4 cycles per instruction.
- lw (100011) with mem_ready low for 3 cycles in MEM_RD -> mem_read=1, i_or_d=1 held 4 cycles. MEM_WB has mem_to_reg=1. Total 8 cycles.
- beq then bne, zero wait -> BRANCH asserts only pc_write_cond, then only pc_write_cond_ne. pc_source=01. 3 cycles each.
- opcode=111111 in DECODE -> FAULT next cycle; fault=1, illegal_op=1; stays in FAULT regardless of run until rst_n=0.
- MEM_TIMEOUT=4, mem_ready stuck 0 in FETCH -> FAULT after 4 wait cycles with illegal_op=0. Repeat with mem_ready=1 on the 4th cycle -> DECODE, no fault.
- Assert rst_n=0 asynchronously during MEM_WR -> mem_write drops immediately; state_out=0.

Source files
------------

// File: rtl/mc_control_fsm_if.sv
// Control bundle between the multi-cycle sequencer (master) and the MIPS datapath (slave):
// IR opcode, memory handshake and all datapath mux/enable controls.
interface mc_control_fsm_if;
    logic       run;
    logic [5:0] opcode;
    logic       mem_ready;

    logic       pc_write;
    logic       pc_write_cond;
    logic       pc_write_cond_ne;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       lu_write;
    logic       slti_en;
    logic       fault;
    logic       illegal_op;
    logic [3:0] state_out;

    modport master (
        input  run, opcode, mem_ready,
        output pc_write, pc_write_cond, pc_write_cond_ne, i_or_d, mem_read, mem_write,
               ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source, lu_write, slti_en, fault, illegal_op, state_out
    );

    modport slave (
        output run, opcode, mem_ready,
        input  pc_write, pc_write_cond, pc_write_cond_ne, i_or_d, mem_read, mem_write,
               ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source, lu_write, slti_en, fault, illegal_op, state_out
    );
endinterface

// File: rtl/mc_control_fsm.sv
// Moore multi-cycle sequencer for the 32-bit MIPS datapath with memory-ready watchdog.
// Optional PERF_CNT_EN adds cycle_cnt / instr_cnt performance counters.
module mc_control_fsm #(
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int unsigned TO_W        = 16
) (
    input  logic clk,
    input  logic rst_n,
`ifdef PERF_CNT_EN
    output logic [31:0] cycle_cnt,
    output logic [31:0] instr_cnt,
`endif
    mc_control_fsm_if.master bus
);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_EXEC_R   = 4'd3,
        S_R_WB     = 4'd4,
        S_MEM_ADDR = 4'd5,
        S_MEM_RD   = 4'd6,
        S_MEM_WB   = 4'd7,
        S_MEM_WR   = 4'd8,
        S_BRANCH   = 4'd9,
        S_JUMP     = 4'd10,
        S_LUI_WB   = 4'd11,
        S_SLTI_EX  = 4'd12,
        S_SLTI_WB  = 4'd13,
        S_FAULT    = 4'd14
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_SLTI  = 6'b001010;

    // Last count value before the watchdog fires on the next stalled cycle
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

    state_e          state_q, state_d;
    logic [TO_W-1:0] wait_q, wait_d;
    logic            fault_q, fault_d;
    logic            illegal_q, illegal_d;

    logic       pc_write_c;
    logic       pc_write_cond_c;
    logic       pc_write_cond_ne_c;
    logic       i_or_d_c;
    logic       mem_read_c;
    logic       mem_write_c;
    logic       ir_write_c;
    logic       reg_dst_c;
    logic       mem_to_reg_c;
    logic       reg_write_c;
    logic       alu_src_a_c;
    logic [1:0] alu_src_b_c;
    logic [1:0] alu_op_c;
    logic [1:0] pc_source_c;
    logic       lu_write_c;
    logic       slti_en_c;
    logic       mem_wait_c;
    state_e     wait_exit_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            wait_q    <= '0;
            fault_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            fault_q   <= fault_d;
            illegal_q <= illegal_d;
        end
    end

    // Next-state and Moore control decode
    always_comb begin
        state_d            = state_q;
        wait_d             = '0;
        fault_d            = fault_q;
        illegal_d          = illegal_q;
        pc_write_c         = 1'b0;
        pc_write_cond_c    = 1'b0;
        pc_write_cond_ne_c = 1'b0;
        i_or_d_c           = 1'b0;
        mem_read_c         = 1'b0;
        mem_write_c        = 1'b0;
        ir_write_c         = 1'b0;
        reg_dst_c          = 1'b0;
        mem_to_reg_c       = 1'b0;
        reg_write_c        = 1'b0;
        alu_src_a_c        = 1'b0;
        alu_src_b_c        = 2'b00;
        alu_op_c           = 2'b00;
        pc_source_c        = 2'b00;
        lu_write_c         = 1'b0;
        slti_en_c          = 1'b0;
        mem_wait_c         = 1'b0;
        wait_exit_c        = S_IDLE;

        case (state_q)
            S_IDLE: begin
                if (bus.run) state_d = S_FETCH;
            end
            S_FETCH: begin
                mem_read_c  = 1'b1;
                alu_src_b_c = 2'b01;
                ir_write_c  = bus.mem_ready;
                pc_write_c  = bus.mem_ready;
                mem_wait_c  = 1'b1;
                wait_exit_c = S_DECODE;
            end
            S_DECODE: begin
                alu_src_b_c = 2'b11;
                case (bus.opcode)
                    OP_RTYPE:      state_d = S_EXEC_R;
                    OP_LW, OP_SW:  state_d = S_MEM_ADDR;
                    OP_BEQ, OP_BNE: state_d = S_BRANCH;
                    OP_J:          state_d = S_JUMP;
                    OP_LUI:        state_d = S_LUI_WB;
                    OP_SLTI:       state_d = S_SLTI_EX;
                    default: begin
                        state_d   = S_FAULT;
                        fault_d   = 1'b1;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_EXEC_R: begin
                alu_src_a_c = 1'b1;
                alu_op_c    = 2'b10;
                state_d     = S_R_WB;
            end
            S_R_WB: begin
                reg_dst_c   = 1'b1;
                reg_write_c = 1'b1;
                state_d     = S_FETCH;
            end
            S_MEM_ADDR: begin
                alu_src_a_c = 1'b1;
                alu_src_b_c = 2'b10;
                state_d     = (bus.opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                mem_read_c  = 1'b1;
                i_or_d_c    = 1'b1;
                mem_wait_c  = 1'b1;
                wait_exit_c = S_MEM_WB;
            end
            S_MEM_WB: begin
                mem_to_reg_c = 1'b1;
                reg_write_c  = 1'b1;
                state_d      = S_FETCH;
            end
            S_MEM_WR: begin
                mem_write_c = 1'b1;
                i_or_d_c    = 1'b1;
                mem_wait_c  = 1'b1;
                wait_exit_c = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a_c        = 1'b1;
                alu_op_c           = 2'b01;
                pc_source_c        = 2'b01;
                pc_write_cond_c    = (bus.opcode == OP_BEQ);
                pc_write_cond_ne_c = (bus.opcode == OP_BNE);
                state_d            = S_FETCH;
            end
            S_JUMP: begin
                pc_write_c  = 1'b1;
                pc_source_c = 2'b10;
                state_d     = S_FETCH;
            end
            S_LUI_WB: begin
                lu_write_c  = 1'b1;
                reg_write_c = 1'b1;
                state_d     = S_FETCH;
            end
            S_SLTI_EX: begin
                alu_src_a_c = 1'b1;
                alu_src_b_c = 2'b10;
                alu_op_c    = 2'b11;
                slti_en_c   = 1'b1;
                state_d     = S_SLTI_WB;
            end
            S_SLTI_WB: begin
                slti_en_c   = 1'b1;
                reg_write_c = 1'b1;
                state_d     = S_FETCH;
            end
            S_FAULT: begin
                state_d = S_FAULT;
            end
            default: begin
                state_d = S_FAULT;
                fault_d = 1'b1;
            end
        endcase

        // Memory handshake: ready wins over the watchdog on the same cycle
        if (mem_wait_c) begin
            if (bus.mem_ready) begin
                state_d = wait_exit_c;
            end else if (wait_q == TO_LAST) begin
                state_d = S_FAULT;
                fault_d = 1'b1;
            end else begin
                wait_d = wait_q + TO_W'(1);
            end
        end
    end

    assign bus.pc_write         = pc_write_c;
    assign bus.pc_write_cond    = pc_write_cond_c;
    assign bus.pc_write_cond_ne = pc_write_cond_ne_c;
    assign bus.i_or_d           = i_or_d_c;
    assign bus.mem_read         = mem_read_c;
    assign bus.mem_write        = mem_write_c;
    assign bus.ir_write         = ir_write_c;
    assign bus.reg_dst          = reg_dst_c;
    assign bus.mem_to_reg       = mem_to_reg_c;
    assign bus.reg_write        = reg_write_c;
    assign bus.alu_src_a        = alu_src_a_c;
    assign bus.alu_src_b        = alu_src_b_c;
    assign bus.alu_op           = alu_op_c;
    assign bus.pc_source        = pc_source_c;
    assign bus.lu_write         = lu_write_c;
    assign bus.slti_en          = slti_en_c;
    assign bus.fault            = fault_q;
    assign bus.illegal_op       = illegal_q;
    assign bus.state_out        = state_q;

`ifdef PERF_CNT_EN
    logic [31:0] cycle_q, cycle_d;
    logic [31:0] instr_q, instr_d;

    // Retire = any entry into FETCH except the initial start from IDLE
    always_comb begin
        cycle_d = cycle_q;
        instr_d = instr_q;
        if (state_q != S_IDLE && state_q != S_FAULT) cycle_d = cycle_q + 32'd1;
        if (state_d == S_FETCH && state_q != S_FETCH && state_q != S_IDLE)
            instr_d = instr_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_q <= '0;
            instr_q <= '0;
        end else begin
            cycle_q <= cycle_d;
            instr_q <= instr_d;
        end
    end

    assign cycle_cnt = cycle_q;
    assign instr_cnt = instr_q;
`endif

endmodule
